// File: rtl/matrix_mac_seq.sv
// 2x2 unsigned matrix product sequencer sharing one external 8x8 multiplier.
// Optional MATRIX_SEQ_SAT_EN: saturate element sums to 16 bits and report ovf.
module matrix_mac_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_flat,
   input  logic [31:0] b_flat,
   output logic [7:0]  mult_a,
   output logic [7:0]  mult_b,
   input  logic [15:0] mult_p,
   output logic [63:0] c_flat,
   output logic        busy,
   output logic        done,
   output logic [3:0]  ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_reg, b_reg;
   logic [16:0] acc [4];
   logic [16:0] fin [4];
   logic [3:0]  s;
   logic [1:0]  acc_k;
   logic [1:0]  a_idx, b_idx;
   logic        accept, issue, accum, finish;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (s[3]) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Step s uses A[s[2]][s[0]] and B[s[0]][s[1]]; accumulate trails issue by one edge.
   always_comb begin
      accept = (state != RUN) && start;
      issue  = (state == RUN) && !s[3];
      accum  = (state == RUN) && (s != 4'd0);
      finish = (state == RUN) && s[3];
      a_idx  = {s[2], s[0]};
      b_idx  = {s[0], s[1]};
      for (int unsigned k = 0; k < 4; k++) fin[k] = acc[k];
      fin[acc_k] = acc[acc_k] + {1'b0, mult_p};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg  <= '0;
         b_reg  <= '0;
         s      <= '0;
         acc_k  <= '0;
         mult_a <= '0;
         mult_b <= '0;
         c_flat <= '0;
         for (int unsigned k = 0; k < 4; k++) acc[k] <= '0;
`ifdef MATRIX_SEQ_SAT_EN
         ovf    <= '0;
`endif
      end else if (accept) begin
         a_reg <= a_flat;
         b_reg <= b_flat;
         s     <= '0;
         for (int unsigned k = 0; k < 4; k++) acc[k] <= '0;
      end else begin
         if (issue) begin
            mult_a <= a_reg[{a_idx, 3'b000} +: 8];
            mult_b <= b_reg[{b_idx, 3'b000} +: 8];
            acc_k  <= s[2:1];
            s      <= s + 4'd1;
         end
         if (accum) begin
            for (int unsigned k = 0; k < 4; k++) acc[k] <= fin[k];
         end
         if (finish) begin
            mult_a <= '0;
            mult_b <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
`ifdef MATRIX_SEQ_SAT_EN
               c_flat[16*k +: 16] <= fin[k][16] ? 16'hFFFF : fin[k][15:0];
               ovf[k]             <= fin[k][16];
`else
               c_flat[16*k +: 16] <= fin[k][15:0];
`endif
            end
         end
      end
   end

`ifndef MATRIX_SEQ_SAT_EN
   assign ovf = 4'h0;
`endif

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Self-checking bench for matrix_mac_seq against an arithmetic matrix-product model.
// Honours MATRIX_SEQ_SAT_EN the same way as the design.
module tb_matrix_mac_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a_flat, b_flat;
   logic [7:0]  mult_a, mult_b;
   logic [15:0] mult_p;
   logic [63:0] c_flat;
   logic        busy, done;
   logic [3:0]  ovf;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_ops [8];
   logic [63:0] last_c;
   logic [3:0]  last_ovf;
   logic [31:0] nxt_a, nxt_b;

   matrix_mac_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a_flat (a_flat),
      .b_flat (b_flat),
      .mult_a (mult_a),
      .mult_b (mult_b),
      .mult_p (mult_p),
      .c_flat (c_flat),
      .busy   (busy),
      .done   (done),
      .ovf    (ovf)
   );

   assign mult_p = mult_a * mult_b;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] el(input logic [31:0] m, input int r, input int c);
      logic [31:0] tmp;
      tmp = m >> (8 * (r * 2 + c));
      return tmp[7:0];
   endfunction

   function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] c;
      logic [3:0]  o;
      logic [16:0] sum;
      logic [15:0] v;
      int          k;
      c = '0;
      o = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            k   = i * 2 + j;
            sum = 17'(el(a, i, 0)) * 17'(el(b, 0, j)) + 17'(el(a, i, 1)) * 17'(el(b, 1, j));
`ifdef MATRIX_SEQ_SAT_EN
            v    = (sum > 17'd65535) ? 16'hFFFF : sum[15:0];
            o[k] = (sum > 17'd65535);
`else
            v    = sum[15:0];
`endif
            c = c | (64'(v) << (16 * k));
         end
      end
      return {o, c};
   endfunction

   task automatic build_ops(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int t = 0; t < 2; t++) begin
               exp_ops[n] = {el(a, i, t), el(b, t, j)};
               n++;
            end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      a_flat = a;
      b_flat = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   // Called one tick after the start edge; mode 1 pokes start mid-run, mode 2 holds start high.
   task automatic finish_check(input logic [31:0] a, input logic [31:0] b, input string tag,
                               input int mode);
      logic [67:0] m;
      m = model(a, b);
      chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
      for (int st = 0; st < 8; st++) begin
         @(posedge clk); #1;
         if (mode == 1 && st == 3) begin
            start  = 1'b1;
            a_flat = ~a;
            b_flat = ~b;
         end
         if (mode == 1 && st == 4) start = 1'b0;
         if (mode == 2 && st == 0) begin
            a_flat = nxt_a;
            b_flat = nxt_b;
         end
         chk($sformatf("%s_ops%0d", tag, st), 64'({mult_a, mult_b}), 64'(exp_ops[st]));
         chk($sformatf("%s_nodone%0d", tag, st), 64'({busy, done}), 64'b10);
      end
      chk({tag, "_hold"}, c_flat, last_c);
      @(posedge clk); #1;
      chk({tag, "_done"}, 64'({busy, done}), 64'b01);
      chk({tag, "_c"}, c_flat, m[63:0]);
      chk({tag, "_ovf"}, 64'(ovf), 64'(m[67:64]));
      chk({tag, "_mult0"}, 64'({mult_a, mult_b}), 64'd0);
      last_c   = m[63:0];
      last_ovf = m[67:64];
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        seen;
      reset  = 1'b1;
      start  = 1'b0;
      a_flat = '0;
      b_flat = '0;
      last_c = '0;
      last_ovf = '0;
      nxt_a = '0;
      nxt_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {mult_a, mult_b, busy, done, ovf}, '0);
      chk("reset_c", c_flat, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_outs", 64'({busy, done}), 64'd0);

      build_ops(32'h04030201, 32'h08070605);
      launch(32'h04030201, 32'h08070605);
      finish_check(32'h04030201, 32'h08070605, "basic", 0);
      chk("basic_const", c_flat, 64'h0032_002B_0016_0013);
      @(posedge clk); #1;
      chk("basic_idle", 64'({busy, done}), 64'd0);

      exp_ops = '{16'h0102, 16'h0004, 16'h0103, 16'h0005,
                  16'h0002, 16'h0104, 16'h0003, 16'h0105};
      launch(32'h01000001, 32'h05040302);
      finish_check(32'h01000001, 32'h05040302, "ident", 0);
      chk("ident_const", c_flat, 64'h0005_0004_0003_0002);
      @(posedge clk); #1;

      build_ops(32'hFFFFFFFF, 32'hFFFFFFFF);
      launch(32'hFFFFFFFF, 32'hFFFFFFFF);
      finish_check(32'hFFFFFFFF, 32'hFFFFFFFF, "ovf", 0);
`ifdef MATRIX_SEQ_SAT_EN
      chk("ovf_const", {c_flat, 60'(ovf)}, {64'hFFFF_FFFF_FFFF_FFFF, 60'hF});
`else
      chk("ovf_const", {c_flat, 60'(ovf)}, {64'hFC02_FC02_FC02_FC02, 60'h0});
`endif
      @(posedge clk); #1;

      build_ops(32'h11223344, 32'h55667788);
      launch(32'h11223344, 32'h55667788);
      finish_check(32'h11223344, 32'h55667788, "ignore", 1);
      @(posedge clk); #1;
      chk("ignore_noext", 64'({busy, done}), 64'd0);

      build_ops(32'h0A0B0C0D, 32'h01020304);
      nxt_a = 32'hF0E0D0C0;
      nxt_b = 32'h80FF7F01;
      a_flat = 32'h0A0B0C0D;
      b_flat = 32'h01020304;
      start  = 1'b1;
      @(posedge clk); #1;
      finish_check(32'h0A0B0C0D, 32'h01020304, "b2b1", 2);
      @(posedge clk); #1;
      chk("b2b_restart", 64'({busy, done}), 64'b10);
      start = 1'b0;
      build_ops(nxt_a, nxt_b);
      finish_check(nxt_a, nxt_b, "b2b2", 0);
      @(posedge clk); #1;

      launch(32'h12345678, 32'h9ABCDEF0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", {mult_a, mult_b, busy, done, ovf}, '0);
      chk("rst_mid_c", c_flat, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      last_c = '0;
      last_ovf = '0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         seen = seen | done | busy;
      end
      chk("rst_no_done", 64'(seen), 64'd0);
      build_ops(32'hC0FFEE01, 32'h0BADF00D);
      launch(32'hC0FFEE01, 32'h0BADF00D);
      finish_check(32'hC0FFEE01, 32'h0BADF00D, "post_rst", 0);
      @(posedge clk); #1;

      for (int r = 0; r < 12; r++) begin
         ra = $urandom;
         rb = $urandom;
         if (r % 3 == 0) begin
            ra = ra | 32'hE0E0E0E0;
            rb = rb | 32'hE0E0E0E0;
         end
         build_ops(ra, rb);
         launch(ra, rb);
         finish_check(ra, rb, $sformatf("rand%0d", r), 0);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
